delayreg_prog: RTL
==================

Name: delayreg_prog

Overview:
- Runtime-programmable register delay line with valid tracking, flush, and a primed indicator.
- The tap chain depth is fixed at build time (MAX_DELAY). The active output delay is selected at run time from 0..MAX_DELAY.
- Used in DSP/datapath alignment where latency differs per mode, so a separate fixed delay line per mode is not needed.

Parameters:
- WIDTH, 16, data width per sample; must be >= 1 (elaboration $error otherwise).
- MAX_DELAY, 8, chain depth in registers; must be >= 1.
- DEFAULT_DELAY, 0, active delay after reset; must be <= MAX_DELAY (elaboration $error otherwise).
- DW, $clog2(MAX_DELAY+1), width of delay-select fields (derived, not overridable).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  shift enable; chain advances only when high
- flush  in  1  clears chain contents and valid bits
- cfg_we  in  1  load new active delay from cfg_delay
- cfg_delay  in  DW  requested delay, 0..MAX_DELAY
- cfg_err  out  1  one-cycle pulse: last cfg_we request exceeded MAX_DELAY
- cur_delay  out  DW  active delay register
- in_vld  in  1  qualifier for data
- data  in  WIDTH  input sample
- delay  out  WIDTH  sample delayed by cur_delay enabled cycles
- out_vld  out  1  qualifier for delay output
- primed  out  1  chain holds at least cur_delay samples since last reset/flush/reconfig
- taps  out  WIDTH*(MAX_DELAY+1)  tap k = data delayed k enabled cycles; tap 0 = data
- tap_vld  out  MAX_DELAY+1  valid bit per tap; bit 0 = in_vld

Behaviour:
- Chain: stages chain[0..MAX_DELAY-1], each holding a data word and a valid bit.
  - When ena=1: chain[0]<=data/in_vld and chain[k]<=chain[k-1].
  - When ena=0: chain holds.
- Reset (rst_n=0 at a clk edge):
  - All chain data and valid bits are 0; fill_cnt=0; cfg_err=0.
  - cur_delay=DEFAULT_DELAY.
  - Reset overrides every other input in that cycle.
- Output selection is combinational from registered state:
  - cur_delay=0: delay=data and out_vld=in_vld (zero-latency pass-through).
  - cur_delay=N>0: delay=chain[N-1].data and out_vld=chain[N-1].vld & primed.
- Latency: with cur_delay=N, the sample presented on the input in the k-th ena cycle appears on delay after the (k+N-1)-th ena cycle's clock edge, i.e. N enabled cycles later.
- fill_cnt (DW bits):
  - Increments on each ena cycle and saturates at MAX_DELAY.
  - Cleared by flush or cfg_we. When cleared, the increment of that same cycle is not applied.
  - primed = (fill_cnt >= cur_delay). primed is therefore always 1 when cur_delay=0.
- flush:
  - Clears all valid bits and data to 0 and clears fill_cnt.
  - Takes priority over ena in the same cycle: no shift, and the input sample is dropped.
- cfg_we:
  - cur_delay <= min(cfg_delay, MAX_DELAY).
  - If cfg_delay > MAX_DELAY: cfg_err=1 for exactly the next cycle; otherwise cfg_err=0.
  - Chain contents are kept, and a shift still occurs if ena=1. Only fill_cnt clears, so out_vld stays masked until re-primed.
- Simultaneous flush+cfg_we: both apply (chain cleared, new delay loaded, fill_cnt=0).
- taps/tap_vld: expose every chain stage unconditionally. They are not masked by primed.
- No combinational path from cfg_* to delay/out_vld. The new delay takes effect the cycle after cfg_we.

Decomposition:
- Shared package delay_pkg:
  - dly_stage_t struct (vld bit + data word, parameterised via WIDTH at the module level).
  - Width helper function dly_w(max) returning $clog2(max+1).
- Natural sub-module: delayreg_fill. It holds fill_cnt, primed, and the saturating clear/increment logic, and is reusable by other variable-latency blocks.
- Chain register and output mux remain in the top module.

Test Plan:
- Reset then MAX_DELAY=8, DEFAULT_DELAY=3, ena=1, in_vld=1, data=1,2,3,... -> out_vld=0 for first 3 cycles; then delay=1,2,3... with out_vld=1; cur_delay=3.
- cfg_we with cfg_delay=0 mid-stream -> next cycle delay==data and out_vld==in_vld; primed=1 immediately.
- cfg_we with cfg_delay=12 (>8) -> cur_delay=8, cfg_err high exactly one cycle; out_vld low for 8 ena cycles then valid with 8-cycle latency.
- Toggle ena 1,0,1,0 with delay=2, data=A,-,B,-,C -> C's cycle outputs A; output held constant on ena=0 cycles.
- flush asserted together with ena=1 and data=0x55 -> all tap_vld[8:1]=0, 0x55 not captured, fill_cnt restarts, out_vld low for cur_delay cycles.
- rst_n=0 asserted for one cycle mid-stream with ena=1 -> next cycle taps[8:1]=0, cur_delay=DEFAULT_DELAY, cfg_err=0, outputs identical to post-power-up.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared helpers for the variable-latency delay blocks.
package delay_pkg;

    function automatic int dly_w(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/delayreg_prog_if.sv
// Data, control and observation signals of the programmable delay line.
interface delayreg_prog_if
    import delay_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_DELAY = 8
);
    localparam int DW = dly_w(MAX_DELAY);

    logic                           ena;
    logic                           flush;
    logic                           cfg_we;
    logic [DW-1:0]                  cfg_delay;
    logic                           cfg_err;
    logic [DW-1:0]                  cur_delay;
    logic                           in_vld;
    logic [WIDTH-1:0]               data;
    logic [WIDTH-1:0]               delay;
    logic                           out_vld;
    logic                           primed;
    logic [WIDTH*(MAX_DELAY+1)-1:0] taps;
    logic [MAX_DELAY:0]             tap_vld;

    modport master (
        output ena, flush, cfg_we, cfg_delay, in_vld, data,
        input  cfg_err, cur_delay, delay, out_vld, primed, taps, tap_vld
    );

    modport slave (
        input  ena, flush, cfg_we, cfg_delay, in_vld, data,
        output cfg_err, cur_delay, delay, out_vld, primed, taps, tap_vld
    );

endinterface

// File: rtl/delayreg_fill.sv
// Saturating fill counter: tracks how many enabled cycles the chain has seen
// since the last clear and reports when that covers the active delay.
module delayreg_fill
    import delay_pkg::*;
#(
    parameter int  MAX_DELAY = 8,
    localparam int DW        = dly_w(MAX_DELAY)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          clr,
    input  logic [DW-1:0] cur_delay,
    output logic          primed
);

    localparam logic [DW-1:0] CNT_MAX = DW'(MAX_DELAY);

    logic [DW-1:0] fill_cnt;

    // A clear wins over the increment of the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            fill_cnt <= '0;
        end else if (ena && (fill_cnt != CNT_MAX)) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    assign primed = (fill_cnt >= cur_delay);

endmodule

// File: rtl/delayreg_prog.sv
// Runtime-programmable register delay line with per-stage valid tracking,
// flush and a primed indicator that masks out_vld until the chain is refilled.
module delayreg_prog
    import delay_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    delayreg_prog_if.slave bus
);

    localparam int DW = dly_w(MAX_DELAY);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);

    if (WIDTH < 1) begin : g_bad_width
        $error("delayreg_prog: WIDTH must be >= 1");
    end
    if (MAX_DELAY < 1) begin : g_bad_depth
        $error("delayreg_prog: MAX_DELAY must be >= 1");
    end
    if (DEFAULT_DELAY < 0 || DEFAULT_DELAY > MAX_DELAY) begin : g_bad_default
        $error("delayreg_prog: DEFAULT_DELAY must be within 0..MAX_DELAY");
    end

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] data;
    } dly_stage_t;

    dly_stage_t [MAX_DELAY-1:0] chain;
    dly_stage_t                 sel;
    logic [DW-1:0]              cur_delay;
    logic                       cfg_err;
    logic                       primed;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            chain <= '0;
        end else if (bus.ena) begin
            chain[0] <= '{vld: bus.in_vld, data: bus.data};
            for (int unsigned k = 1; k < MAX_DELAY; k++) begin
                chain[k] <= chain[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_delay <= DEF_D;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= bus.cfg_we && (bus.cfg_delay > MAX_D);
            if (bus.cfg_we) begin
                cur_delay <= (bus.cfg_delay > MAX_D) ? MAX_D : bus.cfg_delay;
            end
        end
    end

    delayreg_fill #(
        .MAX_DELAY (MAX_DELAY)
    ) u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (bus.ena),
        .clr       (bus.flush | bus.cfg_we),
        .cur_delay (cur_delay),
        .primed    (primed)
    );

    // Compare-per-tap mux keeps the select free of out-of-range indexing.
    always_comb begin
        sel = '{vld: bus.in_vld, data: bus.data};
        for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
            if (cur_delay == DW'(k)) begin
                sel = chain[k-1];
            end
        end
    end

    always_comb begin
        bus.taps             = '0;
        bus.tap_vld          = '0;
        bus.taps[WIDTH-1:0]  = bus.data;
        bus.tap_vld[0]       = bus.in_vld;
        for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
            bus.taps[k*WIDTH +: WIDTH] = chain[k-1].data;
            bus.tap_vld[k]             = chain[k-1].vld;
        end
    end

    assign bus.delay     = sel.data;
    assign bus.out_vld   = sel.vld & primed;
    assign bus.primed    = primed;
    assign bus.cur_delay = cur_delay;
    assign bus.cfg_err   = cfg_err;

endmodule
